pi_txn_queue: RTL

PI_TXN_QUEUE -- requirements
Module: pi_txn_queue

---
 rtl/pistorm_pkg.sv | 59 +++++
 rtl/txn_fifo.sv | 51 +++++
 rtl/pi_txn_queue.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/pistorm_pkg.sv
// Shared definitions for the Pi-side transaction queue: register map,
// STATUS/command bit positions, FIFO geometry and the queued entry record.
package pistorm_pkg;

    // Pi register select values
    localparam logic [1:0] REG_DATA    = 2'd0;
    localparam logic [1:0] REG_ADDR_LO = 2'd1;
    localparam logic [1:0] REG_ADDR_HI = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;

    // STATUS read-back bit positions
    localparam int STAT_BUSY_BIT  = 15;
    localparam int STAT_FULL_BIT  = 14;
    localparam int STAT_OVF_BIT   = 13;
    localparam int STAT_LEVEL_LSB = 10;

    // Bits of the ADDR_HI write word that describe the cycle
    localparam int CMD_BYTE_BIT = 8;
    localparam int CMD_RW_BIT   = 9;

    // STATUS write bit that clears the sticky overflow flag
    localparam int CTRL_CLR_OVF_BIT = 13;

    // FIFO geometry
    localparam int FIFO_DEPTH = 4;
    localparam int FIFO_AW    = 2;
    localparam int LEVEL_W    = 3;

    // One queued 68k bus cycle (43 bits)
    typedef struct packed {
        logic [23:0] addr;
        logic [15:0] wdata;
        logic        rw;     // 1 = read
        logic        uds_n;
        logic        lds_n;
    } txn_entry_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } txn_state_e;

    // Debug view of the control block
    typedef struct packed {
        txn_state_e  state;
        logic [1:0]  rd_sync;
        logic [1:0]  wr_sync;
    } txn_dbg_t;

    // Data strobes {uds_n, lds_n}: word cycles drive both lanes, byte cycles
    // pick the upper lane for even addresses and the lower lane for odd ones.
    function automatic logic [1:0] lane_strobes(input logic byte_op, input logic a0);
        logic [1:0] s;
        if (byte_op) s = {a0, ~a0};
        else         s = 2'b00;
        return s;
    endfunction

endpackage

// File: rtl/txn_fifo.sv
// Four-entry storage for queued bus cycles. A push while full is only taken
// when a pop happens on the same edge; otherwise it is silently dropped and
// the caller is expected to flag the overflow.
module txn_fifo
    import pistorm_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  txn_entry_t         push_data,
    input  logic               pop,
    output txn_entry_t         head,
    output logic               full,
    output logic               empty,
    output logic [LEVEL_W-1:0] level
);

    txn_entry_t         mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic               do_push;
    logic               do_pop;

    assign full    = (level == LEVEL_W'(FIFO_DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Storage, pointers (wrap modulo 4 by width) and occupancy count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/pi_txn_queue.sv
// Pi-facing register file that turns Pi strobe writes into queued 68k bus
// cycles and issues them one at a time over the OP_REQ/OP_ACK handshake.
//
// Handshake: OP_REQ rises with the head entry on OP_ADDR/OP_WDATA/OP_RW/
// OP_UDS_n/OP_LDS_n and holds all of them stable until a single-cycle OP_ACK;
// the entry is popped on the ACK edge and OP_REQ drops on that same edge.
// OP_RDATA is only meaningful in the ACK cycle. ACK while idle is ignored.
module pi_txn_queue
    import pistorm_pkg::*;
(
    input  logic        PI_CLK,
    input  logic        RST,
    input  logic [1:0]  PI_A,
    input  logic        PI_RD,
    input  logic        PI_WR,
    input  logic [15:0] PI_D_IN,
    output logic [15:0] PI_D_OUT,
    output logic        PI_D_OE,
    output logic        PI_TXN_IN_PROGRESS,
    output logic        OP_REQ,
    input  logic        OP_ACK,
    output logic [23:0] OP_ADDR,
    output logic [15:0] OP_WDATA,
    output logic        OP_RW,
    output logic        OP_UDS_n,
    output logic        OP_LDS_n,
    input  logic [15:0] OP_RDATA,
    output logic [15:0] CTRL,
    output txn_dbg_t    dbg
);

    logic [1:0]         rd_sync;
    logic [1:0]         wr_sync;
    logic               wr_rise;
    logic [15:0]        wdata_hold;
    logic [15:0]        addr_hold;
    logic               overflow;
    logic [15:0]        rdata_reg;
    txn_state_e         state;

    txn_entry_t         push_entry;
    txn_entry_t         fifo_head;
    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [LEVEL_W-1:0] fifo_level;

    // Pi strobes are asynchronous: two flops each, rising edge seen on the copy
    always_ff @(posedge PI_CLK or posedge RST) begin
        if (RST) begin
            rd_sync <= '0;
            wr_sync <= '0;
        end else begin
            rd_sync <= {rd_sync[0], PI_RD};
            wr_sync <= {wr_sync[0], PI_WR};
        end
    end

    assign wr_rise   = !wr_sync[1] && wr_sync[0];
    assign fifo_push = wr_rise && (PI_A == REG_ADDR_HI);
    assign fifo_pop  = (state == ST_REQ) && OP_ACK;

    // Assemble the entry described by an ADDR_HI write
    always_comb begin
        push_entry       = '0;
        push_entry.addr  = {PI_D_IN[7:0], addr_hold};
        push_entry.wdata = wdata_hold;
        push_entry.rw    = PI_D_IN[CMD_RW_BIT];
        {push_entry.uds_n, push_entry.lds_n} = lane_strobes(PI_D_IN[CMD_BYTE_BIT], addr_hold[0]);
    end

    txn_fifo u_fifo (
        .clk       (PI_CLK),
        .rst       (RST),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    // Pi register writes: holding registers, CTRL and sticky overflow
    always_ff @(posedge PI_CLK or posedge RST) begin
        if (RST) begin
            wdata_hold <= '0;
            addr_hold  <= '0;
            CTRL       <= '0;
            overflow   <= 1'b0;
        end else if (wr_rise) begin
            case (PI_A)
                REG_DATA:    wdata_hold <= PI_D_IN;
                REG_ADDR_LO: addr_hold  <= PI_D_IN;
                REG_ADDR_HI: if (fifo_full && !fifo_pop) overflow <= 1'b1;
                REG_STATUS: begin
                    CTRL <= PI_D_IN;
                    if (PI_D_IN[CTRL_CLR_OVF_BIT]) overflow <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Issue FSM: latch the head into the OP_* registers and wait for ACK
    always_ff @(posedge PI_CLK or posedge RST) begin
        if (RST) begin
            state     <= ST_IDLE;
            OP_REQ    <= 1'b0;
            OP_ADDR   <= '0;
            OP_WDATA  <= '0;
            OP_RW     <= 1'b1;
            OP_UDS_n  <= 1'b1;
            OP_LDS_n  <= 1'b1;
            rdata_reg <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        state    <= ST_REQ;
                        OP_REQ   <= 1'b1;
                        OP_ADDR  <= fifo_head.addr;
                        OP_WDATA <= fifo_head.wdata;
                        OP_RW    <= fifo_head.rw;
                        OP_UDS_n <= fifo_head.uds_n;
                        OP_LDS_n <= fifo_head.lds_n;
                    end
                end
                ST_REQ: begin
                    if (OP_ACK) begin
                        state  <= ST_IDLE;
                        OP_REQ <= 1'b0;
                        if (OP_RW) rdata_reg <= OP_RDATA;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Registered busy indication for the Pi
    always_ff @(posedge PI_CLK or posedge RST) begin
        if (RST) PI_TXN_IN_PROGRESS <= 1'b0;
        else     PI_TXN_IN_PROGRESS <= (fifo_level != '0) || (state == ST_REQ);
    end

    assign PI_D_OE = PI_RD && ((PI_A == REG_DATA) || (PI_A == REG_STATUS));

    // Pi read mux
    always_comb begin
        PI_D_OUT = '0;
        case (PI_A)
            REG_DATA:   PI_D_OUT = rdata_reg;
            REG_STATUS: PI_D_OUT = {PI_TXN_IN_PROGRESS, fifo_full, overflow, fifo_level, 10'b0};
            default:    PI_D_OUT = '0;
        endcase
    end

    // Debug view
    always_comb begin
        dbg         = '0;
        dbg.state   = state;
        dbg.rd_sync = rd_sync;
        dbg.wr_sync = wr_sync;
    end

endmodule
